// File: rtl/dac_cmd_responder.sv
// Command-bus slave that shifts 16-bit frames to a serial DAC and strobes its LDAC input.
// Optional macro DAC_HOLD_REG_EN adds a one-entry holding register for writes arriving while busy.
`default_nettype none

module dac_cmd_responder #(
  parameter int POSITION = 50,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        overflow,
  output logic        dac_sclk,
  output logic        nSync,
  output logic        dac_din,
  output logic        nLdac
);

  localparam logic [18:0] A_DATA   = 19'(POSITION);
  localparam logic [18:0] A_CTRL   = 19'(POSITION + 1);
  localparam logic [18:0] A_LDAC   = 19'(POSITION + 2);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_LDAC  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  div, div_nx;
  logic        half, half_nx;
  logic        tail, tail_nx;
  logic [3:0]  bit_cnt, bit_cnt_nx;
  logic [15:0] shreg, shreg_nx;
  logic        auto_ldac;
  logic        ldac_req;
  logic        take_hold, take_ldac;
  logic        hold_valid;
  logic [15:0] hold_data;
  logic        store, drop;

  wire unused_hi = &{1'b0, data_in[31:16]};

  wire wr_ok     = enable && data_wr;
  wire wr_data   = wr_ok && (addr == A_DATA);
  wire wr_ctrl   = wr_ok && (addr == A_CTRL);
  wire wr_ldac   = wr_ok && (addr == A_LDAC);
  wire phase_end = (div == DIV_LAST);

  assign busy = !((state == S_IDLE) && !hold_valid && !ldac_req);
  wire start_direct = wr_data && !busy;

`ifdef DAC_HOLD_REG_EN
  assign store = wr_data && busy && !hold_valid;
  assign drop  = wr_data && busy && hold_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (take_hold) begin
      hold_valid <= 1'b0;
    end else if (store) begin
      hold_valid <= 1'b1;
      hold_data  <= data_in[15:0];
    end
  end
`else
  assign store      = 1'b0;
  assign drop       = wr_data && busy;
  assign hold_valid = 1'b0;
  assign hold_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div       <= '0;
      half      <= 1'b0;
      tail      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      auto_ldac <= 1'b1;
      ldac_req  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_nx;
      div     <= div_nx;
      half    <= half_nx;
      tail    <= tail_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      if (wr_ctrl) auto_ldac <= data_in[0];
      if (wr_ldac) ldac_req <= 1'b1;
      else if (take_ldac) ldac_req <= 1'b0;
      if (drop) overflow <= 1'b1;
      else if (wr_ctrl && data_in[1]) overflow <= 1'b0;
    end
  end

  // Timing runs in half-periods of CLK_DIV cycles; 'half' selects the second half of a bit/gap/pulse.
  always_comb begin
    state_nx   = state;
    div_nx     = phase_end ? 8'd0 : div + 8'd1;
    half_nx    = half;
    tail_nx    = tail;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    take_hold  = 1'b0;
    take_ldac  = 1'b0;
    case (state)
      S_IDLE: begin
        div_nx = '0;
        if (hold_valid) begin
          state_nx  = S_SYNC;
          shreg_nx  = hold_data;
          take_hold = 1'b1;
        end else if (start_direct) begin
          state_nx = S_SYNC;
          shreg_nx = data_in[15:0];
        end else if (ldac_req) begin
          state_nx  = S_LDAC;
          half_nx   = 1'b0;
          take_ldac = 1'b1;
        end
      end
      S_SYNC: begin
        if (phase_end) begin
          state_nx   = S_SHIFT;
          half_nx    = 1'b0;
          tail_nx    = 1'b0;
          bit_cnt_nx = 4'd15;
        end
      end
      S_SHIFT: begin
        if (phase_end) begin
          if (tail) begin
            state_nx = S_GAP;
            half_nx  = 1'b0;
            tail_nx  = 1'b0;
          end else if (!half) begin
            half_nx  = 1'b1;
            shreg_nx = {shreg[14:0], 1'b0};
          end else if (bit_cnt == 4'd0) begin
            // Hold nSync low with sclk high for one more half-period after bit0.
            tail_nx = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt - 4'd1;
            half_nx    = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (phase_end) begin
          if (!half) half_nx = 1'b1;
          else begin
            half_nx  = 1'b0;
            state_nx = auto_ldac ? S_LDAC : S_IDLE;
          end
        end
      end
      S_LDAC: begin
        if (phase_end) begin
          if (!half) half_nx = 1'b1;
          else begin
            half_nx  = 1'b0;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign nSync    = !((state == S_SYNC) || (state == S_SHIFT));
  assign dac_sclk = !((state == S_SHIFT) && !tail && !half);
  assign dac_din  = shreg[15];
  assign nLdac    = (state != S_LDAC);

endmodule

`default_nettype wire
